// File: rtl/wb_commit_if.sv
// MEM-stage result, MEM/WB register and register-file read signals for wb_commit.
// The master drives MEM results and read requests; the slave is the write-back block.
interface wb_commit_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic [1:0]    stall_i;
  logic          flush_i;
  logic [AW-1:0] mem_wd;
  logic          mem_wreg;
  logic [DW-1:0] mem_wdata;
  logic          mem_whilo;
  logic [DW-1:0] mem_hi;
  logic [DW-1:0] mem_lo;
  logic [AW-1:0] wb_wd;
  logic          wb_wreg;
  logic [DW-1:0] wb_wdata;
  logic          wb_whilo;
  logic [DW-1:0] wb_hi;
  logic [DW-1:0] wb_lo;
  logic          re1;
  logic          re2;
  logic [AW-1:0] raddr1;
  logic [AW-1:0] raddr2;
  logic [DW-1:0] rdata1;
  logic [DW-1:0] rdata2;
  logic [DW-1:0] hi_o;
  logic [DW-1:0] lo_o;

  modport master (
    output stall_i, flush_i, mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo,
    output re1, re2, raddr1, raddr2,
    input  wb_wd, wb_wreg, wb_wdata, wb_whilo, wb_hi, wb_lo,
    input  rdata1, rdata2, hi_o, lo_o
  );

  modport slave (
    input  stall_i, flush_i, mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo,
    input  re1, re2, raddr1, raddr2,
    output wb_wd, wb_wreg, wb_wdata, wb_whilo, wb_hi, wb_lo,
    output rdata1, rdata2, hi_o, lo_o
  );
endinterface

// File: rtl/wb_commit.sv
// Write-back stage: MEM/WB pipeline register, GPR file and HI/LO commit,
// with two bypassed GPR read ports and a bypassed HI/LO read port.
module wb_commit #(
  parameter int NREGS = 32,
  parameter int DW    = 32,
  parameter int AW    = 5
) (
  input  logic        clk,
  input  logic        rst,
  wb_commit_if.slave  bus
);

  logic [AW-1:0] r_wb_wd;
  logic          r_wb_wreg;
  logic [DW-1:0] r_wb_wdata;
  logic          r_wb_whilo;
  logic [DW-1:0] r_wb_hi;
  logic [DW-1:0] r_wb_lo;

  logic [DW-1:0] r_gpr [NREGS];
  logic [DW-1:0] r_hi;
  logic [DW-1:0] r_lo;

  logic [DW-1:0] w_rdata1;
  logic [DW-1:0] w_rdata2;
  logic [DW-1:0] w_hi;
  logic [DW-1:0] w_lo;

  // Reset, flush and a MEM-only stall all load the same all-zero bubble.
  always_ff @(posedge clk) begin
    if (rst || bus.flush_i || (bus.stall_i == 2'b01)) begin
      r_wb_wd    <= '0;
      r_wb_wreg  <= 1'b0;
      r_wb_wdata <= '0;
      r_wb_whilo <= 1'b0;
      r_wb_hi    <= '0;
      r_wb_lo    <= '0;
    end else if (!bus.stall_i[1]) begin
      r_wb_wd    <= bus.mem_wd;
      r_wb_wreg  <= bus.mem_wreg;
      r_wb_wdata <= bus.mem_wdata;
      r_wb_whilo <= bus.mem_whilo;
      r_wb_hi    <= bus.mem_hi;
      r_wb_lo    <= bus.mem_lo;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gpr <= '{default: '0};
      r_hi  <= '0;
      r_lo  <= '0;
    end else begin
      if (r_wb_wreg && (r_wb_wd != '0)) begin
        r_gpr[r_wb_wd] <= r_wb_wdata;
      end
      if (r_wb_whilo) begin
        r_hi <= r_wb_hi;
        r_lo <= r_wb_lo;
      end
    end
  end

  always_comb begin
    w_rdata1 = '0;
    if (!rst && bus.re1 && (bus.raddr1 != '0)) begin
      if (r_wb_wreg && (bus.raddr1 == r_wb_wd)) w_rdata1 = r_wb_wdata;
      else                                      w_rdata1 = r_gpr[bus.raddr1];
    end
  end

  always_comb begin
    w_rdata2 = '0;
    if (!rst && bus.re2 && (bus.raddr2 != '0)) begin
      if (r_wb_wreg && (bus.raddr2 == r_wb_wd)) w_rdata2 = r_wb_wdata;
      else                                      w_rdata2 = r_gpr[bus.raddr2];
    end
  end

  always_comb begin
    w_hi = '0;
    w_lo = '0;
    if (!rst) begin
      w_hi = r_wb_whilo ? r_wb_hi : r_hi;
      w_lo = r_wb_whilo ? r_wb_lo : r_lo;
    end
  end

  assign bus.wb_wd    = r_wb_wd;
  assign bus.wb_wreg  = r_wb_wreg;
  assign bus.wb_wdata = r_wb_wdata;
  assign bus.wb_whilo = r_wb_whilo;
  assign bus.wb_hi    = r_wb_hi;
  assign bus.wb_lo    = r_wb_lo;
  assign bus.rdata1   = w_rdata1;
  assign bus.rdata2   = w_rdata2;
  assign bus.hi_o     = w_hi;
  assign bus.lo_o     = w_lo;

endmodule

// File: tb/tb_wb_commit.sv
// Directed bench for wb_commit: vector table for pipeline/commit/bypass behaviour,
// plus hand-written sequences for reset during a pending commit and back-to-back writes.
module tb_wb_commit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  wb_commit_if #(.DW(32), .AW(5)) bus ();

  wb_commit #(.NREGS(32), .DW(32), .AW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  stall;
    logic        flush;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        re1;
    logic        re2;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [4:0]  e_wd;
    logic        e_wreg;
    logic [31:0] e_wdata;
    logic        e_whilo;
    logic [31:0] e_r1;
    logic [31:0] e_r2;
    logic [31:0] e_hi;
    logic [31:0] e_lo;
  } vec_t;

  vec_t vec [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_mem(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata);
    bus.mem_wd    = wd;
    bus.mem_wreg  = wreg;
    bus.mem_wdata = wdata;
    bus.mem_whilo = 1'b0;
    bus.mem_hi    = '0;
    bus.mem_lo    = '0;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //          stall flush wd  wreg wdata         whilo hi            lo            re1 re2 a1 a2  e_wd e_wreg e_wdata     e_whilo e_r1        e_r2          e_hi          e_lo
    vec[0]  = '{2'b00, 0, 5'd5, 1, 32'hDEADBEEF, 0, 32'h0,        32'h0,        1, 1, 5'd5, 5'd0, 5'd5, 1, 32'hDEADBEEF, 0, 32'hDEADBEEF, 32'h0,        32'h0,        32'h0};
    vec[1]  = '{2'b00, 0, 5'd0, 0, 32'h0,        0, 32'h0,        32'h0,        1, 1, 5'd5, 5'd5, 5'd0, 0, 32'h0,        0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        32'h0};
    vec[2]  = '{2'b00, 0, 5'd0, 1, 32'h12345678, 0, 32'h0,        32'h0,        1, 1, 5'd0, 5'd5, 5'd0, 1, 32'h12345678, 0, 32'h0,        32'hDEADBEEF, 32'h0,        32'h0};
    vec[3]  = '{2'b00, 0, 5'd0, 0, 32'h0,        0, 32'h0,        32'h0,        1, 1, 5'd0, 5'd5, 5'd0, 0, 32'h0,        0, 32'h0,        32'hDEADBEEF, 32'h0,        32'h0};
    vec[4]  = '{2'b00, 0, 5'd0, 0, 32'h0,        1, 32'hAAAA0000, 32'h0000BBBB, 1, 1, 5'd5, 5'd0, 5'd0, 0, 32'h0,        1, 32'hDEADBEEF, 32'h0,        32'hAAAA0000, 32'h0000BBBB};
    vec[5]  = '{2'b00, 0, 5'd0, 0, 32'h0,        0, 32'h11111111, 32'h22222222, 1, 1, 5'd5, 5'd0, 5'd0, 0, 32'h0,        0, 32'hDEADBEEF, 32'h0,        32'hAAAA0000, 32'h0000BBBB};
    vec[6]  = '{2'b01, 0, 5'd7, 1, 32'h1,        0, 32'h0,        32'h0,        1, 1, 5'd7, 5'd5, 5'd0, 0, 32'h0,        0, 32'h0,        32'hDEADBEEF, 32'hAAAA0000, 32'h0000BBBB};
    vec[7]  = '{2'b00, 0, 5'd7, 1, 32'h1,        0, 32'h0,        32'h0,        1, 1, 5'd7, 5'd5, 5'd7, 1, 32'h1,        0, 32'h1,        32'hDEADBEEF, 32'hAAAA0000, 32'h0000BBBB};
    vec[8]  = '{2'b11, 0, 5'd8, 1, 32'h22,       1, 32'h33,       32'h44,       1, 1, 5'd7, 5'd8, 5'd7, 1, 32'h1,        0, 32'h1,        32'h0,        32'hAAAA0000, 32'h0000BBBB};
    vec[9]  = '{2'b00, 1, 5'd8, 1, 32'h22,       1, 32'h33,       32'h44,       1, 1, 5'd7, 5'd8, 5'd0, 0, 32'h0,        0, 32'h1,        32'h0,        32'hAAAA0000, 32'h0000BBBB};
    vec[10] = '{2'b00, 0, 5'd0, 0, 32'h0,        0, 32'h0,        32'h0,        0, 1, 5'd7, 5'd7, 5'd0, 0, 32'h0,        0, 32'h0,        32'h1,        32'hAAAA0000, 32'h0000BBBB};
    vec[11] = '{2'b10, 0, 5'd9, 1, 32'h99,       1, 32'h55,       32'h66,       1, 1, 5'd9, 5'd7, 5'd0, 0, 32'h0,        0, 32'h0,        32'h1,        32'hAAAA0000, 32'h0000BBBB};

    bus.stall_i = 2'b00;
    bus.flush_i = 1'b0;
    drive_mem(5'd0, 1'b0, 32'h0);
    bus.re1    = 1'b1;
    bus.re2    = 1'b1;
    bus.raddr1 = 5'd5;
    bus.raddr2 = 5'd9;

    // Reset held for two cycles
    step();
    step();
    chk("rst_rdata1", bus.rdata1, 32'h0);
    rst = 1'b0;
    chk("rst_wb_wd",    32'(bus.wb_wd), 32'h0);
    chk("rst_wb_wreg",  32'(bus.wb_wreg), 32'h0);
    chk("rst_wb_wdata", bus.wb_wdata, 32'h0);
    chk("rst_wb_whilo", 32'(bus.wb_whilo), 32'h0);
    chk("rst_wb_hi",    bus.wb_hi, 32'h0);
    chk("rst_wb_lo",    bus.wb_lo, 32'h0);
    chk("rst_hi_o",     bus.hi_o, 32'h0);
    chk("rst_lo_o",     bus.lo_o, 32'h0);
    for (int a = 0; a < 32; a++) begin
      bus.raddr1 = 5'(a);
      bus.raddr2 = 5'(31 - a);
      #1;
      chk($sformatf("rst_gpr1[%0d]", a), bus.rdata1, 32'h0);
      chk($sformatf("rst_gpr2[%0d]", 31 - a), bus.rdata2, 32'h0);
    end

    for (int i = 0; i < 12; i++) begin
      bus.stall_i   = vec[i].stall;
      bus.flush_i   = vec[i].flush;
      bus.mem_wd    = vec[i].wd;
      bus.mem_wreg  = vec[i].wreg;
      bus.mem_wdata = vec[i].wdata;
      bus.mem_whilo = vec[i].whilo;
      bus.mem_hi    = vec[i].hi;
      bus.mem_lo    = vec[i].lo;
      bus.re1       = vec[i].re1;
      bus.re2       = vec[i].re2;
      bus.raddr1    = vec[i].a1;
      bus.raddr2    = vec[i].a2;
      step();
      chk($sformatf("v%0d.wb_wd", i),    32'(bus.wb_wd),    32'(vec[i].e_wd));
      chk($sformatf("v%0d.wb_wreg", i),  32'(bus.wb_wreg),  32'(vec[i].e_wreg));
      chk($sformatf("v%0d.wb_wdata", i), bus.wb_wdata,      vec[i].e_wdata);
      chk($sformatf("v%0d.wb_whilo", i), 32'(bus.wb_whilo), 32'(vec[i].e_whilo));
      chk($sformatf("v%0d.rdata1", i),   bus.rdata1,        vec[i].e_r1);
      chk($sformatf("v%0d.rdata2", i),   bus.rdata2,        vec[i].e_r2);
      chk($sformatf("v%0d.hi_o", i),     bus.hi_o,          vec[i].e_hi);
      chk($sformatf("v%0d.lo_o", i),     bus.lo_o,          vec[i].e_lo);
    end

    // Reset arrives while a write to $9 is pending in WB; HI/LO also cleared
    bus.stall_i = 2'b00;
    bus.flush_i = 1'b0;
    bus.re1     = 1'b1;
    bus.re2     = 1'b1;
    bus.raddr1  = 5'd9;
    bus.raddr2  = 5'd9;
    drive_mem(5'd9, 1'b1, 32'h55);
    step();
    chk("rstmid_bypass", bus.rdata1, 32'h55);
    chk("rstmid_wreg", 32'(bus.wb_wreg), 32'h1);
    rst = 1'b1;
    drive_mem(5'd0, 1'b0, 32'h0);
    step();
    chk("rstmid_in_rst_rdata1", bus.rdata1, 32'h0);
    chk("rstmid_in_rst_wreg", 32'(bus.wb_wreg), 32'h0);
    rst = 1'b0;
    step();
    chk("rstmid_gpr9", bus.rdata1, 32'h0);
    chk("rstmid_hi_o", bus.hi_o, 32'h0);
    chk("rstmid_lo_o", bus.lo_o, 32'h0);

    // Back-to-back writes to the same register
    for (int v = 1; v <= 3; v++) begin
      drive_mem(5'd9, 1'b1, 32'(v));
      step();
      chk($sformatf("b2b_rdata1[%0d]", v), bus.rdata1, 32'(v));
    end
    drive_mem(5'd0, 1'b0, 32'h0);
    step();
    chk("b2b_final_rdata1", bus.rdata1, 32'h3);
    chk("b2b_final_rdata2", bus.rdata2, 32'h3);
    step();
    chk("b2b_stored_rdata1", bus.rdata1, 32'h3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
